cpu_int_sequencer: RTL

- Sequences the 6502 core's interrupt and reset entry: RESET, NMI, BRK (opcode 8'h00) and IRQ.
- Arbitrates between the four sources at instruction boundaries.
- Drives the memory bus for the stack pushes and the vector fetch, then hands the control unit a new PC, SP and I flag.
- Sits beside the main control FSM, which releases the bus whenever busy=1.

---
 rtl/cpu_int_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_int_sequencer.sv
// 6502 interrupt/reset entry sequencer: arbitrates RESET/NMI/BRK/IRQ at instruction
// boundaries, pushes PC and P onto the stack, fetches the vector and hands back PC/SP/I.
module cpu_int_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RST    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        boundary,
    input  logic        brk,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        pc_load,
    output logic [15:0] pc_out,
    output logic        sp_load,
    output logic [7:0]  sp_out,
    output logic        set_i,
    output logic [1:0]  src
);

    typedef enum logic [2:0] {IDLE, PCH, PCL, PSH, VLO, VHI, FIN} state_t;

    localparam logic [1:0] SRC_RST = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_BRK = 2'd2;
    localparam logic [1:0] SRC_IRQ = 2'd3;

    state_t      state_q, state_d;
    logic        nmi_s1, nmi_s2, irq_s1, irq_s2;
    logic        nmi_pend, rst_pend;
    logic [1:0]  src_q, acc_src;
    logic        accept;
    logic [7:0]  ptr, push_p, lo;
    logic [15:0] push_pc, vec_q;
    logic        vec_nmi_q;

    // nmi_set fires in the cycle the synchronised line is about to fall, so a
    // vector decision on that same edge already sees the new NMI.
    logic nmi_set, nmi_hit, irq_req;
    assign nmi_set = nmi_s2 & ~nmi_s1;
    assign nmi_hit = nmi_pend | nmi_set;
    assign irq_req = ~irq_s2 & ~i_flag;
    assign src     = src_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        acc_src   = SRC_IRQ;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        busy      = 1'b0;
        pc_load   = 1'b0;
        pc_out    = 16'h0000;
        sp_load   = 1'b0;
        sp_out    = 8'h00;
        set_i     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_pend) begin
                    accept  = 1'b1;
                    acc_src = SRC_RST;
                end else if (boundary) begin
                    if (nmi_hit) begin
                        accept  = 1'b1;
                        acc_src = SRC_NMI;
                    end else if (brk) begin
                        accept  = 1'b1;
                        acc_src = SRC_BRK;
                    end else if (irq_req) begin
                        accept  = 1'b1;
                        acc_src = SRC_IRQ;
                    end
                end
                if (accept) state_d = PCH;
            end
            PCH: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, ptr};
                mem_wdata = push_pc[15:8];
                mem_we    = (src_q != SRC_RST);
                state_d   = PCL;
            end
            PCL: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, ptr};
                mem_wdata = push_pc[7:0];
                mem_we    = (src_q != SRC_RST);
                state_d   = PSH;
            end
            PSH: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, ptr};
                mem_wdata = push_p;
                mem_we    = (src_q != SRC_RST);
                state_d   = VLO;
            end
            VLO: begin
                busy     = 1'b1;
                mem_addr = vec_q;
                state_d  = VHI;
            end
            VHI: begin
                busy     = 1'b1;
                mem_addr = vec_q + 16'd1;
                state_d  = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                pc_load = 1'b1;
                pc_out  = {mem_rdata, lo};
                sp_load = 1'b1;
                sp_out  = ptr;
                set_i   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nmi_s1   <= 1'b1;
            nmi_s2   <= 1'b1;
            irq_s1   <= 1'b1;
            irq_s2   <= 1'b1;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
        end else begin
            nmi_s1   <= nmi_n;
            nmi_s2   <= nmi_s1;
            irq_s1   <= irq_n;
            irq_s2   <= irq_s1;
            nmi_pend <= nmi_set | (nmi_pend & ~(state_q == VLO && vec_nmi_q));
            if (state_q == FIN) rst_pend <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            src_q     <= SRC_RST;
            ptr       <= 8'h00;
            push_pc   <= 16'h0000;
            push_p    <= 8'h00;
            vec_q     <= 16'h0000;
            vec_nmi_q <= 1'b0;
            lo        <= 8'h00;
        end else begin
            if (accept) begin
                src_q   <= acc_src;
                ptr     <= sp_in;
                push_pc <= (acc_src == SRC_BRK) ? pc_in + 16'd2 : pc_in;
                push_p  <= (p_in & 8'hEF) | 8'h20 | {3'b000, acc_src == SRC_BRK, 4'h0};
            end
            if (state_q == PCH || state_q == PCL || state_q == PSH) ptr <= ptr - 8'd1;
            // Late NMI hijacks a BRK/IRQ entry; the pushed B bit is left as it was.
            if (state_q == PSH) begin
                if (src_q == SRC_RST) begin
                    vec_q     <= VEC_RST;
                    vec_nmi_q <= 1'b0;
                end else if (nmi_hit) begin
                    vec_q     <= VEC_NMI;
                    vec_nmi_q <= 1'b1;
                    src_q     <= SRC_NMI;
                end else begin
                    vec_q     <= VEC_IRQ;
                    vec_nmi_q <= 1'b0;
                end
            end
            if (state_q == VHI) lo <= mem_rdata;
        end
    end

endmodule
